// File: rtl/gcd_stein_seq.sv
// -----------------------------------------------------------------------------
// gcd_stein_seq
//
// Iterative binary (Stein) GCD engine. One shift or subtract step is taken per
// clock. Operands are accepted through a valid/ready handshake while the engine
// is idle. The result is offered through a valid/ready handshake and is held
// until the consumer takes it.
//
// Optional feature (compile-time macro GCD_CYCLE_COUNT_EN):
//   When defined, a `cycles` output reports how many STRIP/REDUCE cycles the
//   current result took. When undefined, the port and its counter do not exist.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      a/b are valid
//   in_ready   out  1      engine can accept operands (IDLE only)
//   a, b       in   WIDTH  unsigned operands
//   out_valid  out  1      result is valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  gcd(a, b)
//   busy       out  1      engine is in STRIP or REDUCE
//   cycles     out  CNT_W  compute-cycle count (GCD_CYCLE_COUNT_EN only)
// -----------------------------------------------------------------------------
module gcd_stein_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(3*WIDTH+2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STRIP  = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Both differences are computed unconditionally; only the one whose
    // minuend is the larger operand is ever selected, so neither wraps in use.
    logic [WIDTH-1:0] diff_xy;
    logic [WIDTH-1:0] diff_yx;

    assign diff_xy = x_q - y_q;
    assign diff_yx = y_q - x_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = '0;
                    state_d = S_STRIP;
                end
            end

            // Remove the common power of two, remembering it in k.
            S_STRIP: begin
                if (x_q == '0) begin
                    result_d = y_q;
                    state_d  = S_DONE;
                end else if (y_q == '0) begin
                    result_d = x_q;
                    state_d  = S_DONE;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + K_W'(1);
                end else begin
                    state_d = S_REDUCE;
                end
            end

            // At least one operand is odd here, so a lone even operand can
            // drop its factor of two, and the difference of two odd values is
            // even and can be halved in the same step.
            S_REDUCE: begin
                if (x_q == '0) begin
                    result_d = y_q << k_q;
                    state_d  = S_DONE;
                end else if (y_q == '0) begin
                    result_d = x_q << k_q;
                    state_d  = S_DONE;
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q >= y_q) begin
                    x_d = diff_xy >> 1;
                end else begin
                    y_d = diff_yx >> 1;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs are pure decodes of the state register, so nothing
    // on the consumer side can reach them combinationally.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_STRIP) || (state_q == S_REDUCE);
    assign result    = result_q;

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if ((state_q == S_IDLE) && in_valid) begin
            cycles_d = '0;
        end else if (busy) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_stein_seq.sv
module tb_gcd_stein_seq;

    logic clk = 1'b0;
    logic reset;

    logic       iv8, ir8, ov8, or8, busy8;
    logic [7:0] a8, b8, r8;

    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] a16, b16, r16;

`ifdef GCD_CYCLE_COUNT_EN
    localparam int C8  = $clog2(3*8+2);
    localparam int C16 = $clog2(3*16+2);
    logic [C8-1:0]  cyc8;
    logic [C16-1:0] cyc16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stein_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .result(r8), .busy(busy8)
`ifdef GCD_CYCLE_COUNT_EN
        , .cycles(cyc8)
`endif
    );

    gcd_stein_seq #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset),
        .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .result(r16), .busy(busy16)
`ifdef GCD_CYCLE_COUNT_EN
        , .cycles(cyc16)
`endif
    );

    typedef struct {
        bit          wide;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          exp_lat;   // -1: only bound-checked
        int          exp_cyc;   // -1: not checked
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Handshake invariant: never ready for input and offering output at once.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ((ir8 && ov8) || (ir16 && ov16)) begin
                errors++;
                $display("FAIL ready_valid_overlap: in_ready8=%0b out_valid8=%0b in_ready16=%0b out_valid16=%0b",
                         ir8, ov8, ir16, ov16);
            end
        end
    end

    function automatic logic get_ov(input bit wide);
        return wide ? ov16 : ov8;
    endfunction

    function automatic logic get_ir(input bit wide);
        return wide ? ir16 : ir8;
    endfunction

    function automatic logic [15:0] get_res(input bit wide);
        return wide ? r16 : {8'h00, r8};
    endfunction

    function automatic int get_cyc(input bit wide);
`ifdef GCD_CYCLE_COUNT_EN
        return wide ? int'(cyc16) : int'(cyc8);
`else
        return -1;
`endif
    endfunction

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] t;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic set_in(input bit wide, input logic v, input logic [15:0] av, input logic [15:0] bv);
        if (wide) begin
            iv16 = v; a16 = av; b16 = bv;
        end else begin
            iv8 = v; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    // Returns with time at 1 unit after the handshake edge.
    task automatic start_op(input bit wide, input logic [15:0] av, input logic [15:0] bv);
        int guard = 0;
        while (!get_ir(wide) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!get_ir(wide)) check("in_ready_timeout", 0, 1);
        set_in(wide, 1'b1, av, bv);
        @(posedge clk); #1;
        set_in(wide, 1'b0, 16'h1234, 16'h5678);
    endtask

    // Latency counts the handshake cycle as 1, so a result produced by a
    // single compute cycle is seen at latency 2.
    task automatic wait_out(input bit wide, output logic [15:0] res, output int lat, output int cyc);
        lat = 1;
        while (!get_ov(wide) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!get_ov(wide)) check("out_valid_timeout", 0, 1);
        res = get_res(wide);
        cyc = get_cyc(wide);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] res;
        int          lat, cyc;

        vecs.push_back('{1'b0, 16'd0,     16'd0,     16'd0,     2, 1});
        vecs.push_back('{1'b0, 16'd8,     16'd4,     16'd4,     7, 6});
        vecs.push_back('{1'b0, 16'd4,     16'd0,     16'd4,    -1, -1});
        vecs.push_back('{1'b0, 16'd0,     16'd5,     16'd5,    -1, -1});
        vecs.push_back('{1'b0, 16'd3,     16'd3,     16'd3,    -1, -1});
        vecs.push_back('{1'b0, 16'd10,    16'd4,     16'd2,    -1, -1});
        vecs.push_back('{1'b0, 16'd100,   16'd25,    16'd25,   -1, -1});
        vecs.push_back('{1'b0, 16'd25,    16'd100,   16'd25,   -1, -1});
        vecs.push_back('{1'b0, 16'd120,   16'd10,    16'd10,   -1, -1});
        vecs.push_back('{1'b0, 16'd67,    16'd9,     16'd1,    -1, -1});
        vecs.push_back('{1'b0, 16'd128,   16'd192,   16'd64,   -1, -1});
        vecs.push_back('{1'b0, 16'd255,   16'd255,   16'd255,  -1, -1});
        vecs.push_back('{1'b1, 16'd65535, 16'd65535, 16'd65535, -1, -1});
        vecs.push_back('{1'b1, 16'd32768, 16'd49152, 16'd16384, -1, -1});

        reset = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_in_ready8",   ir8,   1);
        check("rst_out_valid8",  ov8,   0);
        check("rst_busy8",       busy8, 0);
        check("rst_result8",     r8,    0);
        check("rst_in_ready16",  ir16,  1);
        check("rst_out_valid16", ov16,  0);
        check("rst_result16",    r16,   0);
`ifdef GCD_CYCLE_COUNT_EN
        check("rst_cycles8", cyc8, 0);
`endif

        // Table-driven vectors.
        foreach (vecs[i]) begin
            start_op(vecs[i].wide, vecs[i].a, vecs[i].b);
            check($sformatf("busy_after_hs[%0d]", i), vecs[i].wide ? busy16 : busy8, 1);
            wait_out(vecs[i].wide, res, lat, cyc);
            check($sformatf("result[%0d]", i), res, vecs[i].exp);
            if (vecs[i].exp_lat >= 0)
                check($sformatf("latency[%0d]", i), lat, vecs[i].exp_lat);
            else
                check($sformatf("latency_bound[%0d]", i), lat <= (vecs[i].wide ? 51 : 27), 1);
`ifdef GCD_CYCLE_COUNT_EN
            if (vecs[i].exp_cyc >= 0)
                check($sformatf("cycles[%0d]", i), cyc, vecs[i].exp_cyc);
`endif
        end

        // Backpressure: hold the result for 10 cycles while a stray request is offered.
        or8 = 1'b0;
        start_op(1'b0, 16'd100, 16'd25);
        wait_out(1'b0, res, lat, cyc);
        check("bp_result_first", res, 25);
        set_in(1'b0, 1'b1, 16'd3, 16'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_result[%0d]", i), r8, 25);
            check($sformatf("bp_hold_valid[%0d]", i), ov8, 1);
            check($sformatf("bp_hold_ready[%0d]", i), ir8, 0);
        end
        set_in(1'b0, 1'b0, 16'd0, 16'd0);
        or8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", ir8, 1);
        check("bp_release_out_valid", ov8, 0);
        check("bp_release_busy", busy8, 0);

        // Reset in the middle of a computation.
        start_op(1'b0, 16'd255, 16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop_busy_before", busy8, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_busy",      busy8, 0);
        check("midop_out_valid", ov8,   0);
        check("midop_result",    r8,    0);
        check("midop_in_ready",  ir8,   1);
        start_op(1'b0, 16'd6, 16'd9);
        wait_out(1'b0, res, lat, cyc);
        check("after_reset_result", res, 3);

        // Random 16-bit pairs against a Euclid reference.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) ra = 16'd0;
            if (i % 70 == 1) rb = 16'd0;
            if (i % 30 == 2) rb = ra << ($urandom_range(0, 3));
            start_op(1'b1, ra, rb);
            wait_out(1'b1, res, lat, cyc);
            check($sformatf("rand_result(%0d,%0d)", ra, rb), res, ref_gcd(ra, rb));
            check($sformatf("rand_latency(%0d,%0d)", ra, rb), lat <= 51, 1);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_stein_seq.md
# gcd_stein_seq

Parametrised, multi-cycle binary (Stein) GCD engine with valid/ready handshakes on its input and output. It is the next generation of the 8-bit `gcd_stein` block. It generalises operand width and computes iteratively, one shift/subtract step per clock. It sits between an operand producer and a result consumer, either of which may stall.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.
- `CNT_W`, default `$clog2(3*WIDTH+2)`: width of the iteration counter. Used only when `GCD_CYCLE_COUNT_EN` is defined.
- `clk`  in  1  clock. Everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `in_valid`  in  1  operands `a`/`b` are valid.
- `in_ready`  out  1  engine can accept operands. High only in IDLE.
- `a`  in  WIDTH  first operand, unsigned.
- `b`  in  WIDTH  second operand, unsigned.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  gcd(a, b).
- `busy`  out  1  high in STRIP or REDUCE.
- `cycles`  out  CNT_W  compute-cycle count for the current result. Present only with `GCD_CYCLE_COUNT_EN`.

## Operation
- Internal registers: `x`, `y` (WIDTH bits each) and a shift count `k` (`$clog2(WIDTH)+1` bits).
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, load `x`←`a`, `y`←`b`, `k`←0, then go to STRIP.
- STRIP, one action per cycle, checked in this priority order:
  - If `x`==0: `result`←`y`, go to DONE.
  - Else if `y`==0: `result`←`x`, go to DONE.
  - Else if both are even: shift `x` and `y` right by 1, `k`←`k`+1, stay in STRIP.
  - Else go to REDUCE, with no data change.
- REDUCE, one action per cycle, checked in this priority order:
  - If `x`==0: `result`←`y<<k`, go to DONE.
  - Else if `y`==0: `result`←`x<<k`, go to DONE.
  - Else if `x` is even: `x`←`x>>1`.
  - Else if `y` is even: `y`←`y>>1`.
  - Else if `x`>=`y`: `x`←`(x-y)>>1`.
  - Else `y`←`(y-x)>>1`.
- DONE:
  - `out_valid`=1. `result` (and `cycles`) are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- Arithmetic is unsigned. Subtraction is only performed when the minuend is greater than or equal to the subtrahend, so it never wraps.
- `y<<k` cannot overflow, because the GCD never exceeds max(a, b).
- Zero operands: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
- Inputs are ignored outside IDLE. `a`/`b` may change freely once captured.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, `cycles`=0, `x`=`y`=`k`=0.
- Reset asserted in any state aborts the computation. The engine is in IDLE on the next edge, and any pending result is discarded.
- Input handshake at edge N puts the engine in STRIP during cycle N+1. `busy` goes high in that same cycle.
- Each STRIP/REDUCE step takes exactly one cycle.
  - STRIP: at most WIDTH+1 cycles.
  - REDUCE: at most 2*WIDTH+1 cycles.
  - Worst-case handshake-to-`out_valid` latency: 3*WIDTH+3 cycles.
- `out_valid` rises in the cycle after the terminating STRIP/REDUCE step.
- With `out_ready` held high, DONE lasts exactly one cycle. IDLE follows, so there is a minimum of one dead cycle before the next operand is accepted.
- `in_ready` and `out_valid` are never high together.
- `out_valid` and `result` come directly from registers, with no combinational path from `out_ready`.

## Configuration
- `GCD_CYCLE_COUNT_EN` defined:
  - Adds the `cycles` port and its counter.
  - The counter clears on the input handshake, increments on every STRIP/REDUCE cycle, and holds during DONE.
- `GCD_CYCLE_COUNT_EN` not defined:
  - No `cycles` port and no counter logic.
  - All other behaviour and timing is identical.

## Test plan
- WIDTH=8: reset for 2 cycles, then a=0, b=0. Require `out_valid` exactly 2 cycles after the handshake edge, `result`=0, and `cycles`=1.
- WIDTH=8: a=8,b=4 → 4; 4,0 → 4; 3,3 → 3; 10,4 → 2; 100,25 → 25; 25,100 → 25; 120,10 → 10; 67,9 → 1. For (8,4), `cycles`=6.
- Backpressure: a=100, b=25 with `out_ready`=0 for 10 cycles after `out_valid`. Require `result`=25 to stay stable, `in_ready`=0, and a new `in_valid` to be ignored. Release `out_ready`; `in_ready` must be 1 on the next cycle.
- Reset mid-operation: a=255, b=1, then assert `reset` 3 cycles after the handshake. Require `busy`=0, `out_valid`=0, `result`=0 after the edge. Then a=6, b=9 → 3.
- WIDTH=16: a=65535, b=65535 → 65535; a=32768, b=49152 → 16384. Latency must stay ≤ 51 cycles. Also run 1000 random pairs checked against a reference GCD.
